// File: rtl/dmem_sp_arbiter.sv
// Single-ported data SRAM arbiter: load priority with bounded store starvation,
// RD_LAT-deep tag pipe and credit-limited in-order load response FIFO.
module dmem_sp_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LDTAG_W    = 4,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RESP_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [LDTAG_W-1:0]    ld_tag,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_W-1:0]     st_addr,
    input  logic [DATA_W-1:0]     st_wdata,
    input  logic [DATA_W/8-1:0]   st_wstrb,
    output logic                  ld_resp_valid,
    input  logic                  ld_resp_ready,
    output logic [DATA_W-1:0]     ld_resp_data,
    output logic [LDTAG_W-1:0]    ld_resp_tag,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int unsigned CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned ST_W  = $clog2(STARVE_MAX + 1);

    logic                ld_gnt, st_gnt, ld_ok, push, pop, full;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    fcnt_q, fcnt_d;
    logic [ST_W-1:0]     starve_q, starve_d;
    logic [RD_LAT-1:0]   pipe_v_q, pipe_v_d;
    logic [LDTAG_W-1:0]  pipe_tag_q [RD_LAT];
    logic [LDTAG_W-1:0]  pipe_tag_d [RD_LAT];
    logic [DATA_W-1:0]   fifo_data_q [RESP_DEPTH];
    logic [DATA_W-1:0]   fifo_data_d [RESP_DEPTH];
    logic [LDTAG_W-1:0]  fifo_tag_q [RESP_DEPTH];
    logic [LDTAG_W-1:0]  fifo_tag_d [RESP_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        ld_ok  = cnt_q < CNT_W'(RESP_DEPTH);
        st_gnt = rst_n && st_valid &&
                 ((starve_q == ST_W'(STARVE_MAX)) || !(ld_valid && ld_ok));
        ld_gnt = rst_n && ld_valid && ld_ok && !st_gnt;
    end

    assign ld_ready      = ld_gnt;
    assign st_ready      = st_gnt;
    assign mem_en        = ld_gnt || st_gnt;
    assign mem_we        = st_gnt;
    assign mem_addr      = st_gnt ? st_addr : (ld_gnt ? ld_addr : '0);
    assign mem_wdata     = st_gnt ? st_wdata : '0;
    assign mem_wstrb     = st_gnt ? st_wstrb : '0;

    assign ld_resp_valid = (fcnt_q != '0);
    assign ld_resp_data  = fifo_data_q[rd_ptr_q];
    assign ld_resp_tag   = fifo_tag_q[rd_ptr_q];

    always_comb begin
        push = pipe_v_q[RD_LAT-1];
        pop  = ld_resp_valid && ld_resp_ready;
        full = (fcnt_q == CNT_W'(RESP_DEPTH));

        cnt_d = cnt_q;
        if (ld_gnt && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!ld_gnt && pop)
            cnt_d = cnt_q - 1'b1;

        starve_d = starve_q;
        if (!st_valid || st_gnt)
            starve_d = '0;
        else if (starve_q != ST_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;

        pipe_v_d      = pipe_v_q;
        pipe_tag_d    = pipe_tag_q;
        pipe_v_d[0]   = ld_gnt;
        pipe_tag_d[0] = ld_tag;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end

        // Pop-then-push at full reuses the head slot being read out this cycle.
        fifo_data_d = fifo_data_q;
        fifo_tag_d  = fifo_tag_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fcnt_d      = fcnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_tag_d[wr_ptr_q]  = pipe_tag_q[RD_LAT-1];
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push && !pop)
            fcnt_d = fcnt_q + 1'b1;
        else if (!push && pop)
            fcnt_d = fcnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            fcnt_q   <= '0;
            starve_q <= '0;
            pipe_v_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++)
                pipe_tag_q[i] <= '0;
            for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tag_q[i]  <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            fcnt_q      <= fcnt_d;
            starve_q    <= starve_d;
            pipe_v_q    <= pipe_v_d;
            pipe_tag_q  <= pipe_tag_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_data_q <= fifo_data_d;
            fifo_tag_q  <= fifo_tag_d;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: tb/tb_dmem_sp_arbiter.sv
// Scoreboard bench for dmem_sp_arbiter: one RD_LAT=1 instance for arbitration,
// credit and reset behaviour, one RD_LAT=3 instance for pipelined ordering.
module tb_dmem_sp_arbiter;
    localparam int unsigned AW = 32, DW = 64, TW = 4, SW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ld_valid, ld_ready, st_valid, st_ready;
    logic [AW-1:0] ld_addr, st_addr, mem_addr;
    logic [TW-1:0] ld_tag, resp_tag;
    logic [DW-1:0] st_wdata, resp_data, mem_wdata, mem_rdata;
    logic [SW-1:0] st_wstrb, mem_wstrb;
    logic          resp_valid, resp_ready, mem_en, mem_we;

    logic          b_ld_valid, b_ld_ready, b_st_valid, b_st_ready;
    logic [AW-1:0] b_ld_addr, b_st_addr, b_mem_addr;
    logic [TW-1:0] b_ld_tag, b_resp_tag;
    logic [DW-1:0] b_st_wdata, b_resp_data, b_mem_wdata, b_mem_rdata, b_p0, b_p1;
    logic [SW-1:0] b_st_wstrb, b_mem_wstrb;
    logic          b_resp_valid, b_resp_ready, b_mem_en, b_mem_we;

    dmem_sp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LDTAG_W(TW), .RD_LAT(1),
                      .RESP_DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_wstrb(st_wstrb),
        .ld_resp_valid(resp_valid), .ld_resp_ready(resp_ready),
        .ld_resp_data(resp_data), .ld_resp_tag(resp_tag),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata));

    dmem_sp_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LDTAG_W(TW), .RD_LAT(3),
                      .RESP_DEPTH(4), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(b_ld_valid), .ld_ready(b_ld_ready), .ld_addr(b_ld_addr), .ld_tag(b_ld_tag),
        .st_valid(b_st_valid), .st_ready(b_st_ready), .st_addr(b_st_addr),
        .st_wdata(b_st_wdata), .st_wstrb(b_st_wstrb),
        .ld_resp_valid(b_resp_valid), .ld_resp_ready(b_resp_ready),
        .ld_resp_data(b_resp_data), .ld_resp_tag(b_resp_tag),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata));

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } resp_t;

    resp_t sb_a[$];
    resp_t sb_b[$];
    int checks = 0;
    int errors = 0;

    // SRAM contents are a fixed function of the address.
    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
        if (a == 32'h100) return 64'hCAFE;
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) mem_rdata <= data_of(mem_addr);
    always @(posedge clk) begin
        b_p0        <= data_of(b_mem_addr);
        b_p1        <= b_p0;
        b_mem_rdata <= b_p1;
    end

    always @(negedge clk) begin : mon_a
        resp_t e;
        if (rst_n) begin
            if (ld_valid && ld_ready) sb_a.push_back(resp_t'{ld_tag, data_of(ld_addr)});
            if (resp_valid && resp_ready) begin
                if (sb_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_a_unexpected actual tag=%0h required no response", resp_tag);
                end else begin
                    e = sb_a.pop_front();
                    chk("resp_a_tag", resp_tag, e.tag);
                    chk("resp_a_data", resp_data, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        resp_t e;
        if (rst_n) begin
            if (b_ld_valid && b_ld_ready) sb_b.push_back(resp_t'{b_ld_tag, data_of(b_ld_addr)});
            if (b_resp_valid && b_resp_ready) begin
                if (sb_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_b_unexpected actual tag=%0h required no response", b_resp_tag);
                end else begin
                    e = sb_b.pop_front();
                    chk("resp_b_tag", b_resp_tag, e.tag);
                    chk("resp_b_data", b_resp_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic       seen;
        logic [9:0] exp_st2 = 10'b10_0001_0000;
        logic [7:0] exp_ld3 = 8'b1000_1111;

        ld_valid = 1'b1; ld_addr = '0; ld_tag = '0;
        st_valid = 1'b1; st_addr = '0; st_wdata = '0; st_wstrb = '0;
        resp_ready = 1'b0;
        b_ld_valid = 1'b0; b_ld_addr = '0; b_ld_tag = '0;
        b_st_valid = 1'b0; b_st_addr = '0; b_st_wdata = '0; b_st_wstrb = '0;
        b_resp_ready = 1'b1;

        tick(); #2;
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_st_ready", st_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_b_resp_valid", b_resp_valid, 0);
        tick();
        ld_valid = 1'b0; st_valid = 1'b0; rst_n = 1'b1;
        tick();

        // Single load, minimum latency
        tick();
        resp_ready = 1'b1; ld_valid = 1'b1; ld_addr = 32'h100; ld_tag = 4'd3;
        #2;
        chk("t1_ld_ready", ld_ready, 1);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_wstrb", mem_wstrb, 0);
        tick(); ld_valid = 1'b0; #2;
        chk("t1_resp_early", resp_valid, 0);
        tick(); #2;
        chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_tag", resp_tag, 3);
        chk("t1_resp_data", resp_data, 64'hCAFE);
        tick(); #2;
        chk("t1_resp_after", resp_valid, 0);

        // Store only
        tick();
        st_valid = 1'b1; st_addr = 32'h40; st_wdata = 64'h1122_3344_5566_7788; st_wstrb = 8'h0F;
        #2;
        chk("t6_st_ready", st_ready, 1);
        chk("t6_ld_ready", ld_ready, 0);
        chk("t6_mem_en", mem_en, 1);
        chk("t6_mem_we", mem_we, 1);
        chk("t6_mem_addr", mem_addr, 32'h40);
        chk("t6_mem_wstrb", mem_wstrb, 8'h0F);
        chk("t6_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        tick(); st_valid = 1'b0; #2;
        chk("t6_idle_mem_en", mem_en, 0);
        chk("t6_idle_wdata", mem_wdata, 0);
        for (int i = 0; i < 2; i++) begin
            tick(); #2;
            chk("t6_no_resp", resp_valid, 0);
        end

        // Both requesting: store escapes starvation every fifth cycle
        seen = 1'b0;
        ld_addr = 32'h200; ld_tag = 4'd0; st_addr = 32'h80;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (seen) begin ld_addr = ld_addr + 32'd8; ld_tag = ld_tag + 4'd1; end
            ld_valid = 1'b1; st_valid = 1'b1;
            #2;
            chk("t2_ld_ready", ld_ready, !exp_st2[i]);
            chk("t2_st_ready", st_ready, exp_st2[i]);
            seen = ld_ready;
        end
        tick(); ld_valid = 1'b0; st_valid = 1'b0;
        repeat (4) tick();

        // Credit exhaustion under backpressure
        seen = 1'b0;
        ld_addr = 32'h400; ld_tag = 4'd8; st_addr = 32'h88;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (seen) begin ld_addr = ld_addr + 32'd8; ld_tag = ld_tag + 4'd1; end
            ld_valid = 1'b1;
            st_valid = (i == 4);
            resp_ready = (i == 6);
            #2;
            chk("t3_ld_ready", ld_ready, exp_ld3[i]);
            chk("t3_st_ready", st_ready, (i == 4));
            if (i < 4) chk("t3_resp_valid", resp_valid, (i >= 2));
            seen = ld_ready;
        end
        tick(); ld_valid = 1'b0; st_valid = 1'b0; resp_ready = 1'b1;
        repeat (7) tick();
        #2;
        chk("t3_drained", resp_valid, 0);

        // RD_LAT=3 back-to-back loads
        for (int i = 0; i < 3; i++) begin
            tick();
            b_ld_valid = 1'b1; b_ld_tag = 4'(i + 1); b_ld_addr = 32'h300 + 32'(8 * i);
            #2;
            chk("t4_ld_ready", b_ld_ready, 1);
        end
        tick(); b_ld_valid = 1'b0; #2;
        chk("t4_resp_early", b_resp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick(); #2;
            chk("t4_resp_valid", b_resp_valid, 1);
            chk("t4_resp_tag", b_resp_tag, 64'(i + 1));
        end
        tick(); #2;
        chk("t4_resp_after", b_resp_valid, 0);

        // Reset with loads in flight
        tick();
        resp_ready = 1'b1; ld_valid = 1'b1; ld_addr = 32'h500; ld_tag = 4'd5;
        #2; chk("t5_ld0_ready", ld_ready, 1);
        tick(); ld_addr = 32'h508; ld_tag = 4'd6;
        #2; chk("t5_ld1_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0; rst_n = 1'b0;
        sb_a.delete(); sb_b.delete();
        #2;
        chk("t5_resp_in_rst", resp_valid, 0);
        tick();
        rst_n = 1'b1; ld_valid = 1'b1; ld_addr = 32'h510; ld_tag = 4'd7;
        #2;
        chk("t5_ld_after_rst", ld_ready, 1);
        chk("t5_no_stale_resp", resp_valid, 0);
        tick(); ld_valid = 1'b0; #2;
        chk("t5_no_stale_resp2", resp_valid, 0);
        tick(); #2;
        chk("t5_new_resp_valid", resp_valid, 1);
        chk("t5_new_resp_tag", resp_tag, 7);
        repeat (3) begin
            tick(); #2;
            chk("t5_quiet", resp_valid, 0);
        end

        chk("sb_a_empty", sb_a.size(), 0);
        chk("sb_b_empty", sb_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
